// File: rtl/rightshift_seq32_pkg.sv
// Shared ALU constants for the shift path: widths, FSM encoding and opcode bit.
package rightshift_seq32_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int STAGE_W = 3;

    // Instruction bit that selects SRA over SRL in the decoder.
    localparam int SRA_OPC_BIT = 30;

    localparam logic [STAGE_W-1:0] K_FIRST = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_e;

endpackage

// File: rtl/rightshift_seq32_if.sv
// Start/result bus of the sequential right shifter.
interface rightshift_seq32_if;
    import rightshift_seq32_pkg::*;

    logic               ctrl_shift;
    logic               sra;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  data_in;
    logic [DATA_W-1:0]  data_out;
    logic               data_resultRDY;
    logic               busy;

    modport master (
        output ctrl_shift, sra, shamt, data_in,
        input  data_out, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_shift, sra, shamt, data_in,
        output data_out, data_resultRDY, busy
    );

endinterface

// File: rtl/rightshift_seq32_stage.sv
// One power-of-two right-shift stage; the counter selects which stage is applied.
module rightshift_stage
    import rightshift_seq32_pkg::*;
(
    input  logic [DATA_W-1:0]  work,
    input  logic [STAGE_W-1:0] k,
    input  logic               en,
    input  logic               fill,
    output logic [DATA_W-1:0]  shifted
);

    always_comb begin
        shifted = work;
        if (en) begin
            case (k)
                3'd4:    shifted = {{16{fill}}, work[31:16]};
                3'd3:    shifted = {{8{fill}},  work[31:8]};
                3'd2:    shifted = {{4{fill}},  work[31:4]};
                3'd1:    shifted = {{2{fill}},  work[31:2]};
                3'd0:    shifted = {fill,       work[31:1]};
                default: shifted = work;
            endcase
        end
    end

endmodule

// File: rtl/rightshift_seq32.sv
// Sequential SRL/SRA: resolves shift stages 16,8,4,2,1 over five cycles.
module rightshift_seq32
    import rightshift_seq32_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    rightshift_seq32_if.slave   bus
);

    shift_state_e       state_q, state_d;
    logic [STAGE_W-1:0] k_q, k_d;
    logic [DATA_W-1:0]  work_q, work_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic               fill_q, fill_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               rdy_q, busy_q;
    logic [DATA_W-1:0]  stage_out;

    rightshift_stage u_stage (
        .work    (work_q),
        .k       (k_q),
        .en      (shamt_q[k_q]),
        .fill    (fill_q),
        .shifted (stage_out)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        work_d  = work_q;
        shamt_d = shamt_q;
        fill_d  = fill_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                // DONE accepts a start like IDLE so back-to-back ops lose no cycle.
                if (bus.ctrl_shift) begin
                    work_d  = bus.data_in;
                    shamt_d = bus.shamt;
                    fill_d  = bus.sra & bus.data_in[DATA_W-1];
                    k_d     = K_FIRST;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                work_d = stage_out;
                if (k_q == '0) begin
                    dout_d  = stage_out;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= K_FIRST;
            work_q  <= '0;
            shamt_q <= '0;
            fill_q  <= 1'b0;
            dout_q  <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            work_q  <= work_d;
            shamt_q <= shamt_d;
            fill_q  <= fill_d;
            dout_q  <= dout_d;
            rdy_q   <= (state_d == ST_DONE);
            busy_q  <= (state_d == ST_SHIFT);
        end
    end

    assign bus.data_out       = dout_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_rightshift_seq32.sv
// Randomized and directed checks of rightshift_seq32 against an arithmetic reference.
module tb_rightshift_seq32;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    rightshift_seq32_if bus ();

    rightshift_seq32 dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] s, input bit a);
        if (a) return 32'($signed(x) >>> s);
        return x >> s;
    endfunction

    // Start one op, scramble inputs after acceptance, wait for RDY.
    // lat = edges after the accepting edge until RDY is seen; bcnt = cycles busy was high.
    task automatic do_op(input logic [31:0] d, input logic [4:0] s, input bit a,
                         output logic [31:0] res, output int lat, output int bcnt);
        @(negedge clock);
        bus.ctrl_shift = 1'b1;
        bus.data_in = d;
        bus.shamt = s;
        bus.sra = a;
        @(negedge clock);
        bus.ctrl_shift = 1'b0;
        bus.data_in = $urandom;
        bus.sra = 1'($urandom);
        bus.shamt = 5'($urandom);
        lat = -1;
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy) bcnt++;
            if (bus.data_resultRDY) begin
                lat = i;
                break;
            end
            @(negedge clock);
        end
        if (lat < 0) chk("timeout", 32'd0, 32'd1);
        res = bus.data_out;
        @(negedge clock);
        chk("rdy_single", 32'(bus.data_resultRDY), 32'd0);
    endtask

    task automatic op_check(input string tag, input logic [31:0] d, input logic [4:0] s,
                            input bit a, input logic [31:0] exp);
        logic [31:0] r;
        int lat, bc;
        do_op(d, s, a, r, lat, bc);
        chk(tag, r, exp);
        chk({tag, "_lat"}, 32'(lat), 32'd5);
        chk({tag, "_busy"}, 32'(bc), 32'd5);
    endtask

    initial begin
        logic [31:0] d, r;
        logic [4:0]  s;
        bit          a;
        int          lat, bc, gap, seen;

        reset = 1'b1;
        bus.ctrl_shift = 1'b0;
        bus.sra = 1'b0;
        bus.shamt = '0;
        bus.data_in = '0;
        repeat (3) @(negedge clock);
        chk("rst_dout", bus.data_out, 32'h0);
        chk("rst_rdy", 32'(bus.data_resultRDY), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;

        op_check("srl4",    32'h80000000, 5'd4,  1'b0, 32'h08000000);
        op_check("sra4",    32'h80000000, 5'd4,  1'b1, 32'hF8000000);
        op_check("sra31",   32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF);
        op_check("srl0",    32'h12345678, 5'd0,  1'b0, 32'h12345678);
        op_check("srl31",   32'h12345678, 5'd31, 1'b0, 32'h00000000);
        op_check("srl31neg",32'h80000001, 5'd31, 1'b0, 32'h00000001);
        op_check("sra_pos", 32'h7FFF0000, 5'd8,  1'b1, 32'h007FFF00);

        // Back-to-back start in DONE, with an ignored pulse during SHIFT.
        @(negedge clock);
        bus.ctrl_shift = 1'b1;
        bus.data_in = 32'hFFFF0000;
        bus.shamt = 5'd8;
        bus.sra = 1'b0;
        @(negedge clock);
        bus.ctrl_shift = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) begin
                bus.ctrl_shift = 1'b1;
                bus.data_in = 32'hDEADBEEF;
                bus.shamt = 5'd1;
                bus.sra = 1'b1;
            end
            if (i == 3) bus.ctrl_shift = 1'b0;
            if (bus.data_resultRDY) begin
                seen = 1;
                chk("b2b_lat1", 32'(i), 32'd5);
                break;
            end
            @(negedge clock);
        end
        if (seen == 0) chk("b2b_timeout1", 32'd0, 32'd1);
        chk("b2b_res1", bus.data_out, 32'h00FFFF00);
        bus.ctrl_shift = 1'b1;
        bus.data_in = 32'h0000FF00;
        bus.shamt = 5'd4;
        bus.sra = 1'b0;
        @(negedge clock);
        bus.ctrl_shift = 1'b0;
        chk("b2b_busy2", 32'(bus.busy), 32'd1);
        gap = -1;
        for (int i = 1; i < 20; i++) begin
            if (bus.data_resultRDY) begin
                gap = i;
                break;
            end
            @(negedge clock);
        end
        chk("b2b_gap", 32'(gap), 32'd6);
        chk("b2b_res2", bus.data_out, 32'h00000FF0);

        // Reset sampled at E3 discards the op.
        @(negedge clock);
        bus.ctrl_shift = 1'b1;
        bus.data_in = 32'hA5A5A5A5;
        bus.shamt = 5'd3;
        bus.sra = 1'b1;
        @(negedge clock);
        bus.ctrl_shift = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_dout", bus.data_out, 32'h0);
        chk("mrst_rdy", 32'(bus.data_resultRDY), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.data_resultRDY || bus.busy) seen++;
            @(negedge clock);
        end
        chk("mrst_quiet", 32'(seen), 32'd0);

        for (int n = 0; n < 2000; n++) begin
            d = $urandom;
            s = 5'($urandom);
            a = 1'($urandom);
            if (n % 8 == 0) d[31] = 1'b1;
            do_op(d, s, a, r, lat, bc);
            chk("rand", r, ref_shift(d, s, a));
            chk("rand_lat", 32'(lat), 32'd5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
